// File: rtl/nn_pkg.sv
// Shared types and default sizing for the layer sequencer slice.
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    PIXEL,
    DRAIN,
    LAYER2,
    FLUSH,
    DONE
  } state_e;

  localparam int N_PIX_DEF        = 784;
  localparam int N_HID_DEF        = 10;
  localparam int PIPE_LAT_DEF     = 2;
  localparam int DRAIN_CYCLES_DEF = 8;

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Control/address bundle between the sequencer and the ROM/MAC datapath.
// cycle_cnt exists only when SEQ_CYCLE_CNT_EN is defined.
interface nn_layer_sequencer_if
  import nn_pkg::*;
#(
  parameter int N_HID  = N_HID_DEF,
  parameter int PIX_AW = $clog2(N_PIX_DEF),
  parameter int HID_AW = $clog2(N_HID_DEF)
);
  logic              start;
  logic              pix_en;
  logic              busy;
  logic              done;
  logic [HID_AW-1:0] bias_addr;
  logic [N_HID-1:0]  bias_load;
  logic [PIX_AW-1:0] pixel_addr;
  logic              valid_pixel;
  logic [HID_AW-1:0] layer1_addr;
  logic              valid_digit;
  logic [15:0]       frame_cnt;
`ifdef SEQ_CYCLE_CNT_EN
  logic [31:0]       cycle_cnt;

  modport master (
    input  start, pix_en,
    output busy, done, bias_addr, bias_load, pixel_addr, valid_pixel,
           layer1_addr, valid_digit, frame_cnt, cycle_cnt
  );
  modport slave (
    output start, pix_en,
    input  busy, done, bias_addr, bias_load, pixel_addr, valid_pixel,
           layer1_addr, valid_digit, frame_cnt, cycle_cnt
  );
`else
  modport master (
    input  start, pix_en,
    output busy, done, bias_addr, bias_load, pixel_addr, valid_pixel,
           layer1_addr, valid_digit, frame_cnt
  );
  modport slave (
    output start, pix_en,
    input  busy, done, bias_addr, bias_load, pixel_addr, valid_pixel,
           layer1_addr, valid_digit, frame_cnt
  );
`endif
endinterface

// File: rtl/nn_layer_sequencer_valid_delay_line.sv
// Fixed-depth valid shift register; output is the last stage flop.
module valid_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [DEPTH-1:0] r_sr;
  logic [DEPTH-1:0] w_sr_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign w_sr_next[gi] = i_d;
      end else begin : g_tail
        assign w_sr_next[gi] = r_sr[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sr <= '0;
    else        r_sr <= w_sr_next;
  end

  assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/nn_layer_sequencer.sv
// Per-image sequencer: bias preload, pixel stream, drain, layer-2 stream.
// Define SEQ_CYCLE_CNT_EN to add the busy-cycle counter output.
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int N_PIX        = N_PIX_DEF,
  parameter int N_HID        = N_HID_DEF,
  parameter int PIPE_LAT     = PIPE_LAT_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int PIX_AW       = $clog2(N_PIX),
  parameter int HID_AW       = $clog2(N_HID)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nn_layer_sequencer_if.master bus
);
  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_BIAS   = 3'(BIAS);
  localparam logic [2:0] ST_PIXEL  = 3'(PIXEL);
  localparam logic [2:0] ST_DRAIN  = 3'(DRAIN);
  localparam logic [2:0] ST_LAYER2 = 3'(LAYER2);
  localparam logic [2:0] ST_FLUSH  = 3'(FLUSH);
  localparam logic [2:0] ST_DONE   = 3'(DONE);

  localparam int                CNT_W      = $clog2(PIPE_LAT + DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(PIPE_LAT + DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(PIPE_LAT - 1);
  localparam logic [PIX_AW-1:0] PIX_LAST   = PIX_AW'(N_PIX - 1);
  localparam logic [HID_AW-1:0] HID_LAST   = HID_AW'(N_HID - 1);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [HID_AW-1:0] r_bias_addr;
  logic [N_HID-1:0]  r_bias_load;
  logic [PIX_AW-1:0] r_pixel_addr;
  logic [HID_AW-1:0] r_layer1_addr;
  logic [15:0]       r_frame_cnt;
  logic              w_pix_issue;
  logic              w_dig_issue;
  logic              w_valid_pixel;
  logic              w_valid_digit;

  assign w_pix_issue = (r_state == ST_PIXEL) && bus.pix_en;
  assign w_dig_issue = (r_state == ST_LAYER2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_bias_addr   <= '0;
      r_bias_load   <= '0;
      r_pixel_addr  <= '0;
      r_layer1_addr <= '0;
      r_frame_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_state     <= ST_BIAS;
          r_busy      <= 1'b1;
          r_bias_addr <= '0;
          r_bias_load <= N_HID'(1);
        end
        ST_BIAS: if (r_bias_addr == HID_LAST) begin
          r_state     <= ST_PIXEL;
          r_bias_addr <= '0;
          r_bias_load <= '0;
        end else begin
          r_bias_addr <= r_bias_addr + 1'b1;
          r_bias_load <= r_bias_load << 1;
        end
        // Address only advances on an accepted issue; a stall simply re-presents it.
        ST_PIXEL: if (bus.pix_en) begin
          if (r_pixel_addr == PIX_LAST) begin
            r_state      <= ST_DRAIN;
            r_pixel_addr <= '0;
            r_cnt        <= '0;
          end else begin
            r_pixel_addr <= r_pixel_addr + 1'b1;
          end
        end
        ST_DRAIN: if (r_cnt == DRAIN_LAST) begin
          r_state       <= ST_LAYER2;
          r_cnt         <= '0;
          r_layer1_addr <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        ST_LAYER2: if (r_layer1_addr == HID_LAST) begin
          r_state       <= ST_FLUSH;
          r_layer1_addr <= '0;
          r_cnt         <= '0;
        end else begin
          r_layer1_addr <= r_layer1_addr + 1'b1;
        end
        ST_FLUSH: if (r_cnt == FLUSH_LAST) begin
          r_state     <= ST_DONE;
          r_done      <= 1'b1;
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  valid_delay_line #(.DEPTH(PIPE_LAT)) u_pix_valid (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (w_pix_issue),
    .o_q  (w_valid_pixel)
  );

  valid_delay_line #(.DEPTH(PIPE_LAT)) u_dig_valid (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (w_dig_issue),
    .o_q  (w_valid_digit)
  );

`ifdef SEQ_CYCLE_CNT_EN
  logic [31:0] r_run_cnt;
  logic [31:0] r_cycle_cnt;

  // Running count starts at 1 so the first busy cycle is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_cnt   <= '0;
      r_cycle_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (bus.start) r_run_cnt <= 32'd1;
      end else begin
        r_run_cnt <= r_run_cnt + 32'd1;
      end
      if (r_done) r_cycle_cnt <= r_run_cnt;
    end
  end

  assign bus.cycle_cnt = r_cycle_cnt;
`endif

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.bias_addr   = r_bias_addr;
  assign bus.bias_load   = r_bias_load;
  assign bus.pixel_addr  = r_pixel_addr;
  assign bus.valid_pixel = w_valid_pixel;
  assign bus.layer1_addr = r_layer1_addr;
  assign bus.valid_digit = w_valid_digit;
  assign bus.frame_cnt   = r_frame_cnt;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench: per-cycle expected records queued per image, popped and compared each cycle.
module tb_nn_layer_sequencer;
  import nn_pkg::*;

  localparam int N_PIX        = 16;
  localparam int N_HID        = 4;
  localparam int PIPE_LAT     = 2;
  localparam int DRAIN_CYCLES = 3;
  localparam int PIX_AW       = 4;
  localparam int HID_AW       = 2;
  localparam int STALL_AT     = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nn_layer_sequencer_if #(.N_HID(N_HID), .PIX_AW(PIX_AW), .HID_AW(HID_AW)) bus ();

  nn_layer_sequencer #(
    .N_PIX(N_PIX), .N_HID(N_HID), .PIPE_LAT(PIPE_LAT), .DRAIN_CYCLES(DRAIN_CYCLES),
    .PIX_AW(PIX_AW), .HID_AW(HID_AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic              start, pix_en;
    logic              busy, done, vpix, vdig, chk_ba, chk_l1;
    logic [N_HID-1:0]  bias_load;
    logic [HID_AW-1:0] bias_addr, l1;
    logic [PIX_AW-1:0] paddr;
    logic [15:0]       fc;
    logic [31:0]       cc;
  } rec_t;

  rec_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   exp_fc  = 0;
  int   last_cc = 0;
  int   cyc     = 0;

  task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
  endtask

  function automatic bit issued(input int x, input int p0, input int pe, input int stall);
    return (x >= p0) && (x <= pe) && !((x >= p0 + STALL_AT) && (x < p0 + STALL_AT + stall));
  endfunction

  // Expected timeline of one image relative to the cycle in which start is sampled.
  task automatic gen_image(input int stall, input int busy_start, input bit tail,
                           input int last_cyc, input bit hold_start);
    int p0, pe, l0, d, endc, idx;
    rec_t r;
    p0   = 1 + N_HID;
    pe   = p0 + N_PIX + stall - 1;
    l0   = pe + 1 + PIPE_LAT + DRAIN_CYCLES;
    d    = l0 + N_HID + PIPE_LAT;
    endc = tail ? d + 1 : d;
    if (last_cyc >= 0 && last_cyc < endc) endc = last_cyc;
    for (int c = 0; c <= endc; c++) begin
      r = '{default: '0};
      r.start  = (c == 0) || (c == busy_start) || hold_start;
      r.pix_en = !((c >= p0 + STALL_AT) && (c < p0 + STALL_AT + stall));
      r.busy   = (c >= 1) && (c <= d);
      r.done   = (c == d);
      if (c >= 1 && c <= N_HID) begin
        r.bias_load = N_HID'(1 << (c - 1));
        r.bias_addr = HID_AW'(c - 1);
        r.chk_ba    = 1'b1;
      end
      if (c >= p0 && c <= pe) begin
        idx     = c - p0;
        r.paddr = PIX_AW'((idx < STALL_AT) ? idx : ((idx < STALL_AT + stall) ? STALL_AT : idx - stall));
      end
      r.vpix = issued(c - PIPE_LAT, p0, pe, stall);
      if (c >= l0 && c < l0 + N_HID) begin
        r.l1     = HID_AW'(c - l0);
        r.chk_l1 = 1'b1;
      end
      r.vdig = (c - PIPE_LAT >= l0) && (c - PIPE_LAT < l0 + N_HID);
      r.fc   = 16'((c >= d) ? exp_fc + 1 : exp_fc);
      r.cc   = (c > d) ? d : last_cc;
      q.push_back(r);
    end
    if (endc >= d) begin
      exp_fc++;
      last_cc = d;
    end
  endtask

  task automatic run_queue();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(posedge clk);
      #1;
      bus.start  = r.start;
      bus.pix_en = r.pix_en;
      @(negedge clk);
      check("busy", cyc, 32'(bus.busy), 32'(r.busy));
      check("done", cyc, 32'(bus.done), 32'(r.done));
      check("bias_load", cyc, 32'(bus.bias_load), 32'(r.bias_load));
      if (r.chk_ba) check("bias_addr", cyc, 32'(bus.bias_addr), 32'(r.bias_addr));
      check("pixel_addr", cyc, 32'(bus.pixel_addr), 32'(r.paddr));
      check("valid_pixel", cyc, 32'(bus.valid_pixel), 32'(r.vpix));
      if (r.chk_l1) check("layer1_addr", cyc, 32'(bus.layer1_addr), 32'(r.l1));
      check("valid_digit", cyc, 32'(bus.valid_digit), 32'(r.vdig));
      check("frame_cnt", cyc, 32'(bus.frame_cnt), 32'(r.fc));
`ifdef SEQ_CYCLE_CNT_EN
      check("cycle_cnt", cyc, bus.cycle_cnt, r.cc);
`endif
      cyc++;
    end
  endtask

  task automatic check_zero(input string phase);
    check({phase, "_busy"}, cyc, 32'(bus.busy), 32'd0);
    check({phase, "_done"}, cyc, 32'(bus.done), 32'd0);
    check({phase, "_bias_addr"}, cyc, 32'(bus.bias_addr), 32'd0);
    check({phase, "_bias_load"}, cyc, 32'(bus.bias_load), 32'd0);
    check({phase, "_pixel_addr"}, cyc, 32'(bus.pixel_addr), 32'd0);
    check({phase, "_valid_pixel"}, cyc, 32'(bus.valid_pixel), 32'd0);
    check({phase, "_layer1_addr"}, cyc, 32'(bus.layer1_addr), 32'd0);
    check({phase, "_valid_digit"}, cyc, 32'(bus.valid_digit), 32'd0);
    check({phase, "_frame_cnt"}, cyc, 32'(bus.frame_cnt), 32'd0);
`ifdef SEQ_CYCLE_CNT_EN
    check({phase, "_cycle_cnt"}, cyc, bus.cycle_cnt, 32'd0);
`endif
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.pix_en = 1'b1;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    gen_image(0, -1, 1'b1, -1, 1'b0);      // nominal
    run_queue();
    $display("nominal run: frame_cnt=%0d", bus.frame_cnt);

    gen_image(3, -1, 1'b1, -1, 1'b0);      // 3-cycle stall at pixel_addr 5
    run_queue();
    $display("backpressure run: frame_cnt=%0d", bus.frame_cnt);

    gen_image(0, 10, 1'b1, -1, 1'b0);      // start re-asserted while busy
    run_queue();
    $display("start-while-busy run: frame_cnt=%0d", bus.frame_cnt);

    gen_image(0, -1, 1'b0, -1, 1'b1);      // start held high across two images
    gen_image(0, -1, 1'b1, -1, 1'b0);
    run_queue();
    $display("back-to-back runs: frame_cnt=%0d", bus.frame_cnt);

    gen_image(0, -1, 1'b0, 11, 1'b0);      // cycles 0..11, reset lands in cycle 12
    run_queue();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    bus.start = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    exp_fc  = 0;
    last_cc = 0;
    cyc++;
    $display("async reset at cycle 12 applied");

    gen_image(0, -1, 1'b1, -1, 1'b0);      // nominal after reset
    run_queue();
    $display("post-reset nominal run: frame_cnt=%0d", bus.frame_cnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
